// File: rtl/thinpad_checksum_top.sv
// Thinpad SRAM bring-up top: sums N BaseRAM words and writes running sums to ExtRAM,
// reporting each accumulation on the debug write-back trace port.
module thinpad_checksum_top #(
   parameter logic [31:0] BASE_PC = 32'h8000_0000,
   parameter logic [4:0]  WB_REG  = 5'd2
) (
   input  logic        clk_50M,
   input  logic        reset_btn,
   input  logic        clk_11M0592,
   input  logic        clock_btn,
   input  logic [3:0]  touch_btn,
   input  logic [31:0] dip_sw,
   output logic [15:0] leds,
   output logic [7:0]  dpy0,
   output logic [7:0]  dpy1,
   output logic        txd,
   input  logic        rxd,
   inout  wire  [31:0] base_ram_data,
   output logic [19:0] base_ram_addr,
   output logic [3:0]  base_ram_be_n,
   output logic        base_ram_ce_n,
   output logic        base_ram_oe_n,
   output logic        base_ram_we_n,
   inout  wire  [31:0] ext_ram_data,
   output logic [19:0] ext_ram_addr,
   output logic [3:0]  ext_ram_be_n,
   output logic        ext_ram_ce_n,
   output logic        ext_ram_oe_n,
   output logic        ext_ram_we_n,
   output logic [22:0] flash_a,
   inout  wire  [15:0] flash_d,
   output logic        flash_rp_n,
   output logic        flash_ce_n,
   output logic        flash_oe_n,
   output logic        flash_we_n,
   output logic        flash_byte_n,
   output logic        flash_vpen,
   output logic [31:0] debug_wb_pc,
   output logic [3:0]  debug_wb_rf_wen,
   output logic [4:0]  debug_wb_rf_wnum,
   output logic [31:0] debug_wb_rf_wdata
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_SETUP, S_RD_LATCH, S_WR_SETUP, S_WR_HOLD, S_DONE
   } state_t;

   state_t      r_state;
   logic [7:0]  r_n;
   logic [7:0]  r_idx;
   logic [7:0]  r_press;
   logic [31:0] r_sum;
   logic [2:0]  r_btn;
   logic [19:0] r_base_addr;
   logic        r_base_ce_n;
   logic        r_base_oe_n;
   logic [19:0] r_ext_addr;
   logic        r_ext_ce_n;
   logic        r_ext_we_n;
   logic        r_ext_drv;
   logic [31:0] r_ext_wdata;
   logic [3:0]  r_dbg_wen;
   logic [31:0] r_dbg_pc;
   logic [4:0]  r_dbg_wnum;
   logic [31:0] r_dbg_wdata;
   logic [15:0] r_leds;
   logic [7:0]  r_dpy0;
   logic [7:0]  r_dpy1;

   wire         w_btn_rise = r_btn[1] & ~r_btn[2];
   wire  [31:0] w_sum_next = r_sum + base_ram_data;
   wire  [7:0]  w_idx_inc  = r_idx + 8'd1;
   wire         w_unused   = ^{clk_11M0592, touch_btn, rxd, dip_sw[31:8], flash_d};

   function automatic logic [7:0] hex7(input logic [3:0] d);
      case (d)
         4'h0: hex7 = 8'h3F;  4'h1: hex7 = 8'h06;  4'h2: hex7 = 8'h5B;  4'h3: hex7 = 8'h4F;
         4'h4: hex7 = 8'h66;  4'h5: hex7 = 8'h6D;  4'h6: hex7 = 8'h7D;  4'h7: hex7 = 8'h07;
         4'h8: hex7 = 8'h7F;  4'h9: hex7 = 8'h6F;  4'hA: hex7 = 8'h77;  4'hB: hex7 = 8'h7C;
         4'hC: hex7 = 8'h39;  4'hD: hex7 = 8'h5E;  4'hE: hex7 = 8'h79;  default: hex7 = 8'h71;
      endcase
   endfunction

   // Restart button: two-flop synchronizer, edge detect and press counter
   always_ff @(posedge clk_50M or negedge reset_btn) begin
      if (!reset_btn) begin
         r_btn   <= 3'b000;
         r_press <= 8'd0;
      end else begin
         r_btn <= {r_btn[1:0], clock_btn};
         if (w_btn_rise) r_press <= r_press + 8'd1;
      end
   end

   always_ff @(posedge clk_50M or negedge reset_btn) begin
      if (!reset_btn) begin
         r_leds <= 16'd0;
         r_dpy0 <= 8'h3F;
         r_dpy1 <= 8'h3F;
      end else begin
         r_leds <= {r_state == S_DONE, r_sum[14:0]};
         r_dpy0 <= hex7(r_press[3:0]);
         r_dpy1 <= hex7(r_press[7:4]);
      end
   end

   // Sequencer; RAM controls are set on entry to the state that needs them
   always_ff @(posedge clk_50M or negedge reset_btn) begin
      if (!reset_btn) begin
         r_state     <= S_IDLE;
         r_n         <= 8'd0;
         r_idx       <= 8'd0;
         r_sum       <= 32'd0;
         r_base_addr <= 20'd0;
         r_base_ce_n <= 1'b1;
         r_base_oe_n <= 1'b1;
         r_ext_addr  <= 20'd0;
         r_ext_ce_n  <= 1'b1;
         r_ext_we_n  <= 1'b1;
         r_ext_drv   <= 1'b0;
         r_ext_wdata <= 32'd0;
         r_dbg_wen   <= 4'd0;
         r_dbg_pc    <= 32'd0;
         r_dbg_wnum  <= 5'd0;
         r_dbg_wdata <= 32'd0;
      end else begin
         r_dbg_wen <= 4'd0;
         case (r_state)
            S_IDLE: begin
               r_n   <= dip_sw[7:0];
               r_sum <= 32'd0;
               r_idx <= 8'd0;
               if (dip_sw[7:0] == 8'd0) begin
                  r_state <= S_DONE;
               end else begin
                  r_state     <= S_RD_SETUP;
                  r_base_addr <= 20'd0;
                  r_base_ce_n <= 1'b0;
                  r_base_oe_n <= 1'b0;
               end
            end
            S_RD_SETUP: r_state <= S_RD_LATCH;
            S_RD_LATCH: begin
               r_sum       <= w_sum_next;
               r_base_ce_n <= 1'b1;
               r_base_oe_n <= 1'b1;
               r_ext_addr  <= 20'(r_idx);
               r_ext_ce_n  <= 1'b0;
               r_ext_we_n  <= 1'b0;
               r_ext_drv   <= 1'b1;
               r_ext_wdata <= w_sum_next;
               r_dbg_wen   <= 4'hF;
               r_dbg_pc    <= BASE_PC + {22'd0, r_idx, 2'b00};
               r_dbg_wnum  <= WB_REG;
               r_dbg_wdata <= w_sum_next;
               r_state     <= S_WR_SETUP;
            end
            S_WR_SETUP: begin
               r_ext_we_n <= 1'b1;
               r_state    <= S_WR_HOLD;
            end
            S_WR_HOLD: begin
               r_ext_ce_n <= 1'b1;
               r_ext_drv  <= 1'b0;
               r_idx      <= w_idx_inc;
               if (w_idx_inc == r_n) begin
                  r_state <= S_DONE;
               end else begin
                  r_state     <= S_RD_SETUP;
                  r_base_addr <= 20'(w_idx_inc);
                  r_base_ce_n <= 1'b0;
                  r_base_oe_n <= 1'b0;
               end
            end
            S_DONE: begin
               if (w_btn_rise) begin
                  r_sum   <= 32'd0;
                  r_idx   <= 8'd0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign base_ram_data     = 32'hzzzz_zzzz;
   assign ext_ram_data      = r_ext_drv ? r_ext_wdata : 32'hzzzz_zzzz;
   assign flash_d           = 16'hzzzz;
   assign base_ram_addr     = r_base_addr;
   assign base_ram_be_n     = 4'd0;
   assign base_ram_ce_n     = r_base_ce_n;
   assign base_ram_oe_n     = r_base_oe_n;
   assign base_ram_we_n     = 1'b1;
   assign ext_ram_addr      = r_ext_addr;
   assign ext_ram_be_n      = 4'd0;
   assign ext_ram_ce_n      = r_ext_ce_n;
   assign ext_ram_oe_n      = 1'b1;
   assign ext_ram_we_n      = r_ext_we_n;
   assign flash_a           = 23'd0;
   assign flash_rp_n        = 1'b1;
   assign flash_ce_n        = 1'b1;
   assign flash_oe_n        = 1'b1;
   assign flash_we_n        = 1'b1;
   assign flash_byte_n      = 1'b1;
   assign flash_vpen        = 1'b0;
   assign txd               = 1'b1;
   assign leds              = r_leds;
   assign dpy0              = r_dpy0;
   assign dpy1              = r_dpy1;
   assign debug_wb_pc       = r_dbg_pc;
   assign debug_wb_rf_wen   = r_dbg_wen;
   assign debug_wb_rf_wnum  = r_dbg_wnum;
   assign debug_wb_rf_wdata = r_dbg_wdata;

endmodule

// File: tb/tb_thinpad_checksum_top.sv
// Directed bench for thinpad_checksum_top with behavioural BaseRAM/ExtRAM models.
module tb_thinpad_checksum_top;

   logic        clk_50M = 1'b0;
   logic        reset_btn, clk_11M0592, clock_btn, rxd;
   logic [3:0]  touch_btn;
   logic [31:0] dip_sw;
   logic [15:0] leds;
   logic [7:0]  dpy0, dpy1;
   logic        txd;
   wire  [31:0] base_ram_data, ext_ram_data;
   wire  [15:0] flash_d;
   logic [19:0] base_ram_addr, ext_ram_addr;
   logic [3:0]  base_ram_be_n, ext_ram_be_n;
   logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
   logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
   logic [22:0] flash_a;
   logic        flash_rp_n, flash_ce_n, flash_oe_n, flash_we_n, flash_byte_n, flash_vpen;
   logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;

   logic [31:0] base_mem [0:255];
   logic [31:0] ext_mem  [0:255];
   logic [31:0] q_pc[$], q_wnum[$], q_wdata[$];
   int n_tests = 0, n_fail = 0, viol = 0, n_wr = 0, bad = 0;
   bit found;

   always #10 clk_50M = ~clk_50M;

   assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n) ? base_mem[base_ram_addr[7:0]] : 32'hzzzz_zzzz;

   thinpad_checksum_top dut (
      .clk_50M(clk_50M), .reset_btn(reset_btn), .clk_11M0592(clk_11M0592), .clock_btn(clock_btn),
      .touch_btn(touch_btn), .dip_sw(dip_sw), .leds(leds), .dpy0(dpy0), .dpy1(dpy1), .txd(txd), .rxd(rxd),
      .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr), .base_ram_be_n(base_ram_be_n),
      .base_ram_ce_n(base_ram_ce_n), .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
      .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr), .ext_ram_be_n(ext_ram_be_n),
      .ext_ram_ce_n(ext_ram_ce_n), .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n),
      .flash_a(flash_a), .flash_d(flash_d), .flash_rp_n(flash_rp_n), .flash_ce_n(flash_ce_n),
      .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n), .flash_byte_n(flash_byte_n), .flash_vpen(flash_vpen),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
      .debug_wb_rf_wdata(debug_wb_rf_wdata)
   );

   // ExtRAM write capture, trace logging and always-true bus rules, sampled mid-cycle
   always @(negedge clk_50M) begin
      if (reset_btn) begin
         if (!ext_ram_ce_n && !ext_ram_we_n) begin
            ext_mem[ext_ram_addr[7:0]] = ext_ram_data;
            n_wr++;
         end
         if (debug_wb_rf_wen == 4'hF) begin
            q_pc.push_back(debug_wb_pc);
            q_wnum.push_back({27'd0, debug_wb_rf_wnum});
            q_wdata.push_back(debug_wb_rf_wdata);
         end
         if (debug_wb_rf_wen != 4'h0 && debug_wb_rf_wen != 4'hF) viol++;
         if (!base_ram_ce_n && !ext_ram_ce_n) viol++;
      end
      if (base_ram_we_n !== 1'b1 || flash_byte_n !== 1'b1 || txd !== 1'b1 || ext_ram_oe_n !== 1'b1) viol++;
      if (base_ram_be_n !== 4'd0 || ext_ram_be_n !== 4'd0 || flash_a !== 23'd0 || flash_vpen !== 1'b0) viol++;
      if ({flash_rp_n, flash_ce_n, flash_oe_n, flash_we_n} !== 4'hF) viol++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      q_pc.delete(); q_wnum.delete(); q_wdata.delete();
      n_wr = 0;
      for (int k = 0; k < 4; k++) ext_mem[k] = 32'hDEAD_BEEF;
   endtask

   task automatic check_trace(input string tag, input logic [31:0] d0, input logic [31:0] d1);
      chk({tag, "_len"}, 32'(q_pc.size()), 32'd2);
      if (q_pc.size() >= 2) begin
         chk({tag, "_pc0"}, q_pc[0], 32'h8000_0000);
         chk({tag, "_wn0"}, q_wnum[0], 32'd2);
         chk({tag, "_wd0"}, q_wdata[0], d0);
         chk({tag, "_pc1"}, q_pc[1], 32'h8000_0004);
         chk({tag, "_wn1"}, q_wnum[1], 32'd2);
         chk({tag, "_wd1"}, q_wdata[1], d1);
      end
   endtask

   task automatic wait_done(input string tag);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk_50M);
         if (leds[15]) break;
      end
      chk({tag, "_done"}, {31'd0, leds[15]}, 32'd1);
   endtask

   task automatic restart(input logic [31:0] sw);
      reset_btn = 1'b0;
      dip_sw = sw;
      repeat (2) @(negedge clk_50M);
      clear_logs();
      reset_btn = 1'b1;
   endtask

   initial begin
      reset_btn = 1'b0; clock_btn = 1'b0; clk_11M0592 = 1'b0; rxd = 1'b1;
      touch_btn = 4'd0; dip_sw = 32'd2;
      for (int k = 0; k < 256; k++) base_mem[k] = 32'd0;
      base_mem[0] = 32'h0000_0011; base_mem[1] = 32'h0000_0022;
      repeat (3) @(negedge clk_50M);

      // Reset state
      chk("rst_ext_we_n", {31'd0, ext_ram_we_n}, 32'd1);
      chk("rst_ext_ce_n", {31'd0, ext_ram_ce_n}, 32'd1);
      chk("rst_base_ce_n", {31'd0, base_ram_ce_n}, 32'd1);
      chk("rst_base_oe_n", {31'd0, base_ram_oe_n}, 32'd1);
      chk("rst_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
      chk("rst_pc", debug_wb_pc, 32'd0);
      chk("rst_leds", {16'd0, leds}, 32'd0);
      chk("rst_addr", {12'd0, base_ram_addr}, 32'd0);

      // Basic two-word run; leds must settle within 10 cycles of release
      clear_logs();
      reset_btn = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_50M);
         if (leds == 16'h8033) break;
      end
      chk("run1_leds", {16'd0, leds}, 32'h0000_8033);
      check_trace("run1", 32'h11, 32'h33);
      chk("run1_ext0", ext_mem[0], 32'h11);
      chk("run1_ext1", ext_mem[1], 32'h33);
      chk("run1_nwr", 32'(n_wr), 32'd2);

      // Carry out of bit 31 is discarded
      base_mem[0] = 32'hFFFF_FFFF; base_mem[1] = 32'h0000_0002;
      restart(32'd2);
      wait_done("wrap");
      check_trace("wrap", 32'hFFFF_FFFF, 32'h0000_0001);
      chk("wrap_ext1", ext_mem[1], 32'h0000_0001);

      // N == 0 goes straight to DONE
      restart(32'd0);
      repeat (12) @(negedge clk_50M);
      chk("n0_trace", 32'(q_pc.size()), 32'd0);
      chk("n0_nwr", 32'(n_wr), 32'd0);
      chk("n0_leds", {16'd0, leds}, 32'h0000_8000);

      // 20 button presses; every edge landing in DONE replays the trace
      base_mem[0] = 32'h11; base_mem[1] = 32'h22;
      restart(32'd2);
      wait_done("pre_btn");
      clear_logs();
      for (int p = 0; p < 20; p++) begin
         clock_btn = 1'b1; #100;
         clock_btn = 1'b0; #100;
      end
      repeat (30) @(negedge clk_50M);
      wait_done("btn");
      chk("btn_dpy1", {24'd0, dpy1}, 32'h06);
      chk("btn_dpy0", {24'd0, dpy0}, 32'h66);
      chk("btn_leds", {16'd0, leds}, 32'h0000_8033);
      bad = 0;
      if (q_pc.size() == 0 || (q_pc.size() % 2) != 0) bad++;
      for (int k = 0; k < q_pc.size(); k++) begin
         if (q_pc[k] != ((k % 2) ? 32'h8000_0004 : 32'h8000_0000)) bad++;
         if (q_wdata[k] != ((k % 2) ? 32'h33 : 32'h11)) bad++;
      end
      chk("btn_replays", 32'(bad), 32'd0);

      // One isolated press in DONE replays exactly one trace
      clear_logs();
      clock_btn = 1'b1; #100;
      clock_btn = 1'b0;
      repeat (30) @(negedge clk_50M);
      wait_done("replay");
      check_trace("replay", 32'h11, 32'h33);
      chk("replay_dpy0", {24'd0, dpy0}, 32'h6D);

      // Reset during WR_SETUP of word 1 releases the write immediately
      restart(32'd2);
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk_50M);
         if (debug_wb_rf_wen == 4'hF && debug_wb_pc == 32'h8000_0004) begin
            found = 1'b1;
            break;
         end
      end
      chk("abort_found", {31'd0, found}, 32'd1);
      chk("abort_pre_we_n", {31'd0, ext_ram_we_n}, 32'd0);
      reset_btn = 1'b0;
      #1;
      chk("abort_we_n", {31'd0, ext_ram_we_n}, 32'd1);
      chk("abort_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
      chk("abort_ce_n", {31'd0, ext_ram_ce_n}, 32'd1);
      chk("abort_leds", {16'd0, leds}, 32'd0);
      restart(32'd2);
      wait_done("abort");
      check_trace("abort", 32'h11, 32'h33);
      chk("abort_ext1", ext_mem[1], 32'h33);

      chk("bus_rules", 32'(viol), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog so the bench always ends on its own
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
